// File: rtl/dot_seq_ctrl.sv
// Sequencer for the dot-product MAC datapath: buffers operand pairs in a FIFO,
// drives the datapath, controls its clear, and registers each finished sum.
module dot_seq_ctrl #(
    parameter int unsigned  P_WIDTH    = 32,
    parameter int unsigned  FIFO_DEPTH = 4,
    parameter int unsigned  MAX_LEN    = 256,
    localparam int unsigned CNT_W      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [P_WIDTH-1:0] in_a,
    input  logic [P_WIDTH-1:0] in_b,
    input  logic               in_last,
    output logic [P_WIDTH-1:0] dp_a,
    output logic [P_WIDTH-1:0] dp_b,
    output logic               dp_run,
    input  logic [P_WIDTH-1:0] dp_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [P_WIDTH-1:0] res_data,
    output logic [CNT_W-1:0]   res_count,
    output logic               res_trunc
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH} state_t;

    logic [P_WIDTH-1:0] a_mem [FIFO_DEPTH];
    logic [P_WIDTH-1:0] b_mem [FIFO_DEPTH];
    logic               l_mem [FIFO_DEPTH];

    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic               fifo_full, fifo_empty, push, pop;
    logic [P_WIDTH-1:0] head_a, head_b;
    logic               head_last;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               last_q, last_d;
    logic               res_valid_q, res_valid_d;
    logic [P_WIDTH-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0]   res_count_q, res_count_d;
    logic               res_trunc_q, res_trunc_d;

    // Wrap-bit pointers distinguish full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && !fifo_full;
    assign head_a     = a_mem[rd_ptr_q[AW-1:0]];
    assign head_b     = b_mem[rd_ptr_q[AW-1:0]];
    assign head_last  = l_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr_q[AW-1:0]] <= in_a;
            b_mem[wr_ptr_q[AW-1:0]] <= in_b;
            l_mem[wr_ptr_q[AW-1:0]] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_IDLE;
            count_q     <= '0;
            last_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_trunc_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            state_q     <= state_d;
            count_q     <= count_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_trunc_q <= res_trunc_d;
        end
    end

    // Next state, FIFO pop, datapath control and result capture.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        last_d      = last_q;
        pop         = 1'b0;
        dp_run      = 1'b0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_trunc_d = res_trunc_q;

        if (res_valid_q && res_ready) res_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                dp_run = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    last_d  = head_last;
                    if (head_last || (count_q + CNT_W'(1) == CNT_W'(MAX_LEN)))
                        state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!res_valid_q || res_ready) begin
                    // dp_run low clears the accumulator on the capture edge.
                    res_valid_d = 1'b1;
                    res_data_d  = dp_out;
                    res_count_d = count_q;
                    res_trunc_d = !last_q;
                    count_d     = '0;
                    state_d     = fifo_empty ? S_IDLE : S_ACCUM;
                end else begin
                    dp_run = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dp_a      = pop ? head_a : '0;
    assign dp_b      = pop ? head_b : '0;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_count = res_count_q;
    assign res_trunc = res_trunc_q;

endmodule
